univ_shift_reg: RTL
===================

Name: univ_shift_reg

Overview:
- Parametrised universal shift register; successor to the fixed 3-bit SISO right shifter.
- Supports hold, right shift, left shift and parallel load under mode control.
- Adds an autonomous burst-serialise mode: one start pulse loads a word and shifts it out over WIDTH cycles, with busy/done status.
- Used as the common serialiser/deserialiser primitive in the assignment datapath blocks.

Parameters:
- WIDTH, 8, register length in bits; legal range 2 to 64.
- RESET_VAL, 0, value loaded into q on reset; WIDTH bits wide.
- CNT_W, $clog2(WIDTH+1), derived localparam; width of the shift counter.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- mode  input  2  manual op, sampled only when idle: 00 hold, 01 shift right, 10 shift left, 11 parallel load.
- sin_r  input  1  serial input shifted into q[WIDTH-1] on a right shift.
- sin_l  input  1  serial input shifted into q[0] on a left shift.
- pin  input  WIDTH  parallel load data.
- start  input  1  burst request; single-cycle pulse or level.
- dir  input  1  burst direction, sampled with start: 0 right (LSB first), 1 left (MSB first).
- q  output  WIDTH  register contents (parallel out).
- sout_r  output  1  equals q[0], combinational from the register.
- sout_l  output  1  equals q[WIDTH-1], combinational from the register.
- busy  output  1  high while a burst is in progress.
- done  output  1  one-cycle pulse when a burst completes.
- cnt  output  CNT_W  shifts completed in the current burst.

Behaviour:
- Reset (async, immediate):
  - q = RESET_VAL; busy = 0; done = 0; cnt = 0; state = IDLE; latched dir = 0.
  - Reset asserted mid-burst aborts the burst with no done pulse.
- State machine: two states, IDLE and BURST, all registered.
- IDLE:
  - If start = 1: q <= pin, latch dir, cnt <= 0, busy <= 1, go to BURST. start takes priority over mode.
  - Otherwise apply mode:
    - hold: q unchanged.
    - right: q <= {sin_r, q[WIDTH-1:1]}.
    - left: q <= {q[WIDTH-2:0], sin_l}.
    - load: q <= pin.
- BURST:
  - Each edge shifts one bit in the latched direction, filling from sin_r or sin_l respectively; cnt <= cnt + 1.
  - mode, start, pin and dir are ignored.
  - On the edge where cnt goes from WIDTH-1 to WIDTH: busy <= 0, done <= 1, go to IDLE.
- Burst timing, with start sampled at edge k:
  - Load at edge k; shifts at edges k+1 through k+WIDTH.
  - busy is high from after edge k to after edge k+WIDTH-1.
  - Bit i of the loaded word is presented on sout_r (dir = 0) or sout_l (dir = 1) during the cycle after edge k+i, for i = 0 to WIDTH-1. That is exactly WIDTH busy cycles.
  - done is high for the single cycle after edge k+WIDTH. cnt holds WIDTH during that cycle.
  - In the first IDLE cycle after done, start is accepted normally, giving back-to-back bursts with one done cycle between them.
- After a burst completes, q contains the shifted-in serial bits; the register is not cleared.
- The done pulse is cleared on the next edge regardless of inputs.
- cnt holds its value in IDLE until the next start or reset.
- No combinational path from inputs to outputs; sout_r and sout_l depend on q only.

Test Plan:
- WIDTH = 8. Reset while running, then release; mode = 00 for 3 cycles -> q = 0x00, busy = 0, done = 0, cnt = 0 throughout.
- mode = 11, pin = 0xA5, then mode = 01 with sin_r = 1 for 2 cycles -> q goes 0xA5, 0xD2, 0xE9; sout_r goes 1, 0, 1.
- Load 0x81, then mode = 10 with sin_l = 0 for 1 cycle -> q = 0x02, sout_l = 0.
- pin = 0xB4, dir = 0, one-cycle start; sin_r = 0 -> sout_r sequence is 0, 0, 1, 0, 1, 1, 0, 1 over 8 busy cycles; then done = 1 for one cycle with cnt = 8 and q = 0x00.
- Burst with dir = 1, pin = 0xB4; toggle mode and pulse start again mid-burst -> sout_l sequence is 1, 0, 1, 1, 0, 1, 0, 0 with no disturbance; exactly one done pulse.
- Assert rst asynchronously during cycle 4 of a burst -> q = RESET_VAL and busy = 0 immediately, with no done pulse; after release, a start is accepted on the first clock edge.

Source files
------------

// File: rtl/univ_shift_reg.sv
// Universal shift register: hold, shift right/left, parallel load, and an
// autonomous burst-serialise mode that shifts a loaded word out over WIDTH cycles.
//
// Ports:
//   clk, rst         rising-edge clock, asynchronous active-high reset
//   mode[1:0]        manual op when idle: 00 hold, 01 right, 10 left, 11 load
//   sin_r, sin_l     serial fill bits for right / left shifts
//   pin[WIDTH-1:0]   parallel load data
//   start, dir       burst request and direction (0 right/LSB first, 1 left/MSB first)
//   q                register contents
//   sout_r, sout_l   q[0] and q[WIDTH-1]
//   busy, done       burst in progress / one-cycle completion pulse
//   cnt              shifts completed in the current burst
module univ_shift_reg #(
  parameter int WIDTH = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic             sin_r,
  input  logic             sin_l,
  input  logic [WIDTH-1:0] pin,
  input  logic             start,
  input  logic             dir,
  output logic [WIDTH-1:0] q,
  output logic             sout_r,
  output logic             sout_l,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] cnt
);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t           state;
  state_t           state_n;
  logic             burst_dir;
  logic             burst_dir_n;
  logic [WIDTH-1:0] q_n;
  logic [CNT_W-1:0] cnt_n;
  logic             busy_n;
  logic             done_n;
  logic [WIDTH-1:0] shr;
  logic [WIDTH-1:0] shl;

  assign shr    = {sin_r, q[WIDTH-1:1]};
  assign shl    = {q[WIDTH-2:0], sin_l};
  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      q         <= RESET_VAL;
      burst_dir <= 1'b0;
      cnt       <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_n;
      q         <= q_n;
      burst_dir <= burst_dir_n;
      cnt       <= cnt_n;
      busy      <= busy_n;
      done      <= done_n;
    end
  end

  always_comb begin
    state_n     = state;
    q_n         = q;
    burst_dir_n = burst_dir;
    cnt_n       = cnt;
    busy_n      = busy;
    // done is a single-cycle pulse; it only rises on the final burst edge
    done_n      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          q_n         = pin;
          burst_dir_n = dir;
          cnt_n       = '0;
          busy_n      = 1'b1;
          state_n     = BURST;
        end else begin
          unique case (mode)
            2'b00: q_n = q;
            2'b01: q_n = shr;
            2'b10: q_n = shl;
            2'b11: q_n = pin;
          endcase
        end
      end
      BURST: begin
        q_n   = burst_dir ? shl : shr;
        cnt_n = cnt + CNT_W'(1);
        if (cnt == LAST) begin
          busy_n  = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
    endcase
  end

endmodule
